// File: rtl/gpio_pixel_streamer.sv
// ---------------------------------------------------------------------------
// gpio_pixel_streamer
//
// Streams one frame of pixel bytes from a word-addressed pixel RAM to an
// external host over an 8-bit GPIO bus with a 4-phase req/ack handshake.
// A start pulse picks one of two regions: input image or result image.
// Reads are prefetched into a small FIFO so that RAM latency stays hidden
// behind the slow handshake.
//
// Ports
//   clk         rising-edge clock for all logic
//   rst         asynchronous reset, active low
//   start       one-cycle pulse; accepted only when idle
//   region_sel  sampled with start: 0 = input region, 1 = result region
//   mem_addr    18-bit word address to the pixel RAM
//   mem_rd      read strobe; mem_rdata is valid exactly one cycle later
//   mem_rdata   pixel byte from the RAM
//   gpio_data   byte driven to the pins; stable while gpio_req is high
//   gpio_req    4-phase request to the host
//   gpio_ack    host acknowledge; asynchronous, synchronised internally
//   busy        high while a frame is in progress
//   done        one-cycle pulse when the frame has fully handed off
//
// Optional build macro
//   PIXEL_CHECKSUM_EN : when defined, the design appends one extra handshake
//                       byte to every frame. That byte is the modulo-256 sum
//                       of all pixel bytes sent in the frame.
// ---------------------------------------------------------------------------
module gpio_pixel_streamer #(
    parameter int unsigned IN_BASE    = 0,
    parameter int unsigned IN_LEN     = 160000,
    parameter int unsigned OUT_BASE   = 160000,
    parameter int unsigned OUT_LEN    = 40000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        region_sel,
    output logic [17:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  gpio_data,
    output logic        gpio_req,
    input  logic        gpio_ack,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [17:0] IN_BASE18  = 18'(IN_BASE);
    localparam logic [17:0] IN_LEN18   = 18'(IN_LEN);
    localparam logic [17:0] OUT_BASE18 = 18'(OUT_BASE);
    localparam logic [17:0] OUT_LEN18  = 18'(OUT_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [17:0]     r_addr;
    logic [17:0]     r_rd_left;
    logic            r_inflight;

    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;

    logic            r_ack_s1;
    logic            r_ack_s2;
    logic            r_req;
    logic [7:0]      r_data;

    logic [CW:0]     w_occ;
    logic            w_rd;
    logic            w_wr;
    logic            w_pop;
    logic            w_fifo_empty;
    logic            w_hs_idle;
    logic            w_drained;
    logic            w_start_ok;

`ifdef PIXEL_CHECKSUM_EN
    logic [7:0]      r_sum;
    logic            r_ck_sent;
    logic            w_ck_send;
`endif

    // Reads already issued count against FIFO space. Because of this, the
    // FIFO can never be written while it is full.
    assign w_occ        = {1'b0, r_cnt} + {{CW{1'b0}}, r_inflight};
    assign w_rd         = (r_state == S_STREAM) && (r_rd_left != 18'd0)
                          && (w_occ < (CW+1)'(FIFO_DEPTH));
    assign w_wr         = r_inflight;
    assign w_fifo_empty = (r_cnt == '0);
    // A new byte may only be presented once the host has released ack.
    assign w_hs_idle    = !r_req && !r_ack_s2;
    assign w_pop        = w_hs_idle && !w_fifo_empty;
    assign w_drained    = w_fifo_empty && !r_inflight && w_hs_idle;
    assign w_start_ok   = (r_state == S_IDLE) && start;

    assign mem_addr  = r_addr;
    assign mem_rd    = w_rd;
    assign gpio_data = r_data;
    assign gpio_req  = r_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
`ifdef PIXEL_CHECKSUM_EN
        w_ck_send = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                busy = 1'b1;
                if ((r_rd_left == 18'd0) || (w_rd && (r_rd_left == 18'd1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_drained) begin
`ifdef PIXEL_CHECKSUM_EN
                    if (r_ck_sent) begin
                        w_next = S_FINISH;
                    end else begin
                        w_ck_send = 1'b1;
                    end
`else
                    w_next = S_FINISH;
`endif
                end
            end
            S_FINISH: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The address stops at the last word of the region and does not move
    // past it, even though r_rd_left still counts down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= 18'd0;
            r_rd_left  <= 18'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            if (w_start_ok) begin
                r_addr    <= region_sel ? OUT_BASE18 : IN_BASE18;
                r_rd_left <= region_sel ? OUT_LEN18  : IN_LEN18;
            end else if (w_rd) begin
                r_rd_left <= r_rd_left - 18'd1;
                if (r_rd_left != 18'd1) begin
                    r_addr <= r_addr + 18'd1;
                end
            end
        end
    end

    // FIFO storage needs no reset. The pointers and the count decide
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_fifo[r_wp] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
            r_req    <= 1'b0;
            r_data   <= 8'd0;
        end else begin
            r_ack_s1 <= gpio_ack;
            r_ack_s2 <= r_ack_s1;
            if (w_pop) begin
                r_data <= r_fifo[r_rp];
                r_req  <= 1'b1;
`ifdef PIXEL_CHECKSUM_EN
            end else if (w_ck_send) begin
                r_data <= r_sum;
                r_req  <= 1'b1;
`endif
            end else if (r_req && r_ack_s2) begin
                r_req <= 1'b0;
            end
        end
    end

`ifdef PIXEL_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum     <= 8'd0;
            r_ck_sent <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_sum     <= 8'd0;
                r_ck_sent <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_sum <= r_sum + r_fifo[r_rp];
                end
                if (w_ck_send) begin
                    r_ck_sent <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/gpio_pixel_streamer.md
GPIO_PIXEL_STREAMER -- requirements
Module: gpio_pixel_streamer

Interface
REQ-001 Parameter IN_BASE, default 0: first word address of the input image region.
REQ-002 Parameter IN_LEN, default 160000: pixel count of the input region (0x00000..0x270FF).
REQ-003 Parameter OUT_BASE, default 160000: first word address of the result region.
REQ-004 Parameter OUT_LEN, default 40000: pixel count of the result region (0x27100..0x30D3F).
REQ-005 Parameter FIFO_DEPTH, default 4: pixel buffer entries; SHALL be a power of two, at least 2.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-008 start  in  1  one-cycle pulse; begins a frame transfer when idle.
REQ-009 region_sel  in  1  sampled with start; 0 = input region, 1 = result region.
REQ-010 mem_addr  out  18  word address to pixel RAM.
REQ-011 mem_rd  out  1  read strobe; RAM returns mem_rdata exactly 1 cycle later.
REQ-012 mem_rdata  in  8  pixel byte from RAM.
REQ-013 gpio_data  out  8  pixel byte driven to the external pins.
REQ-014 gpio_req  out  1  4-phase request to the external host.
REQ-015 gpio_ack  in  1  asynchronous acknowledge from the host.
REQ-016 busy  out  1  high from the cycle after an accepted start until done.
REQ-017 done  out  1  one-cycle pulse after the last byte's handshake completes.

Function
REQ-018 FSM states: IDLE, STREAM, DRAIN, FINISH; IDLE->STREAM on start; STREAM->DRAIN when the last read is issued; DRAIN->FINISH when the FIFO is empty, no read is in flight and the handshake is idle; FINISH->IDLE after one cycle, with done=1 in FINISH.
REQ-019 On start, latch base/length: region_sel=0 gives IN_BASE/IN_LEN, and region_sel=1 gives OUT_BASE/OUT_LEN; start SHALL be ignored unless the FSM is in IDLE.
REQ-020 The read address SHALL run base, base+1, ..., base+len-1; it never wraps or exceeds base+len-1; 18-bit arithmetic.
REQ-021 mem_rd SHALL be asserted in STREAM only while (FIFO count + in-flight reads) < FIFO_DEPTH; no read SHALL ever be dropped or duplicated.
REQ-022 mem_rdata SHALL be written to the FIFO in the cycle after its mem_rd; a simultaneous FIFO write and pop SHALL keep the count unchanged.
REQ-023 gpio_ack SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-024 Handshake phase 1: with req=0, ack_sync=0 and the FIFO non-empty, pop the FIFO head into gpio_data and set req=1.
REQ-025 Handshake phase 2: hold gpio_data and req=1 until ack_sync=1, then clear req.
REQ-026 Handshake phase 3: the next byte SHALL NOT be presented until ack_sync=0.
REQ-027 gpio_data SHALL be stable whenever req=1.
REQ-028 The byte order on gpio_data SHALL equal the address order.
REQ-029 Exactly len bytes SHALL be transferred per frame.
REQ-030 With the FIFO full, reads SHALL stall; the FIFO is never written when full or popped when empty.

Reset
REQ-031 While rst=0: FSM=IDLE, mem_addr=0, mem_rd=0, gpio_data=0, gpio_req=0, busy=0, done=0, FIFO empty, in-flight flag and synchronizer cleared.
REQ-032 Reset asserted mid-frame SHALL abort immediately; after release, the block waits in IDLE for a new start with no residual bytes.

Configuration
REQ-033 Macro PIXEL_CHECKSUM_EN.
REQ-034 Defined: keep an 8-bit modulo-256 sum of all transferred bytes, cleared on start, and send it as one extra handshake byte after the last pixel, before FINISH.
REQ-035 Undefined: no checksum logic; exactly len bytes are transferred.

Verification
REQ-036 Reset, then start with region_sel=1 and a host that acks 3 cycles after req -> mem_addr 160000..199999 in order, 40000 bytes match RAM contents, one done pulse, busy low afterwards.
REQ-037 Region 0 with RAM[a]=a[7:0] and an instant host -> 160000 bytes follow pattern 0x00,0x01,...,0xFF wrapping; the last address read is 0x270FF.
REQ-038 Host stalls ack for 50 cycles -> FIFO fills to 4; mem_rd stays low; no byte is lost or repeated after the ack resumes.
REQ-039 Start pulsed again while busy with region_sel flipped -> ignored; the frame completes on the original region.
REQ-040 Set IN_LEN=8, pull rst low after 5 bytes, release, then start region 0 -> a clean 8-byte frame starting at address 0 and gpio_req=0 during reset.
REQ-041 With PIXEL_CHECKSUM_EN, IN_LEN=4 and bytes 0x10,0x20,0x30,0xF0 -> a fifth byte 0x50 is sent, then done.
